// File: rtl/ecdh_operand_loader.sv
// ECDH operand loader: assembles {k, Px, Py} from a word stream,
// range-checks them, fires the multiplier and waits for its result.
module ecdh_operand_loader #(
  parameter int BW = 192,
  parameter int W = 32,
  parameter logic [BW-1:0] PRIME =
    192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF,
  parameter int TIMEOUT = 1 << 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          flush,
  output logic [BW-1:0] k,
  output logic [BW-1:0] Px,
  output logic [BW-1:0] Py,
  output logic          start,
  input  logic          mul_valid,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int NW = 3 * BW / W;
  localparam int CW = $clog2(NW);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CHECK,
    S_FIRE,
    S_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3*BW-1:0] sr_q, sr_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      code_q, code_d;

  // Operands come straight from the shift register, which only
  // moves in LOAD, so they hold through FIRE and WAIT.
  assign k  = sr_q[3*BW-1:2*BW];
  assign Px = sr_q[2*BW-1:BW];
  assign Py = sr_q[BW-1:0];

  assign in_ready = (state_q == S_LOAD);
  assign start    = (state_q == S_FIRE);
  assign busy     = (state_q == S_WAIT);
  assign done     = done_q;
  assign err      = err_q;
  assign err_code = code_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    wdog_d  = wdog_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    code_d  = code_q;
    unique case (state_q)
      S_LOAD: begin
        if (flush) begin
          cnt_d = '0;
        end else if (in_valid) begin
          sr_d = {sr_q[3*BW-W-1:0], in_data};
          if (cnt_q == CW'(NW - 1)) begin
            cnt_d   = '0;
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CHECK: begin
        if (k == '0) begin
          code_d  = 2'd1;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else if (Px >= PRIME || Py >= PRIME) begin
          code_d  = 2'd2;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          code_d  = 2'd0;
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the timeout cycle still counts.
        if (mul_valid) begin
          done_d  = 1'b1;
          state_d = S_LOAD;
        end else if (wdog_q == TW'(TIMEOUT - 1)) begin
          code_d  = 2'd3;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          wdog_d = wdog_q + TW'(1);
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      sr_q    <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      wdog_q  <= wdog_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_ecdh_operand_loader.sv
// Bench for ecdh_operand_loader: vector table with a start/err
// scoreboard, plus flush, timeout and reset sequences.
module tb_ecdh_operand_loader;

  localparam int NW = 18;
  localparam logic [191:0] PRIME =
    192'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF;
  localparam logic [191:0] GX =
    192'h188DA80EB03090F67CBF20EB43A18800F4FF0AFD82FF1012;
  localparam logic [191:0] GY =
    192'h07192B95FFC8DA78631011ED6B24CDD573F977A11E794811;

  typedef struct {
    logic [191:0] k;
    logic [191:0] px;
    logic [191:0] py;
    logic         is_err;
    logic [1:0]   code;
  } rec_t;

  logic clk = 1'b0;
  logic rst, in_valid, flush, mul_valid;
  logic [31:0] in_data;

  logic         in_ready, start, busy, done, err;
  logic [1:0]   err_code;
  logic [191:0] k_o, px_o, py_o;

  logic         t_in_ready, t_start, t_busy, t_done, t_err;
  logic [1:0]   t_code;
  logic [191:0] t_k, t_px, t_py;

  int   checks = 0;
  int   errors = 0;
  rec_t sbq[$];
  rec_t sb_ev;
  rec_t vecs[7];

  always #5 clk = ~clk;

  ecdh_operand_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush),
    .k(k_o), .Px(px_o), .Py(py_o),
    .start(start), .mul_valid(mul_valid),
    .busy(busy), .done(done), .err(err),
    .err_code(err_code)
  );

  ecdh_operand_loader #(.TIMEOUT(16)) dut_t (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(t_in_ready),
    .in_data(in_data), .flush(flush),
    .k(t_k), .Px(t_px), .Py(t_py),
    .start(t_start), .mul_valid(mul_valid),
    .busy(t_busy), .done(t_done), .err(t_err),
    .err_code(t_code)
  );

  task automatic chk(input string nm,
                     input logic [191:0] act,
                     input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // Scoreboard: every start or err pulse must match the oldest
  // expected outcome.
  always @(negedge clk) begin
    if (!rst && (start || err)) begin
      if (sbq.size() == 0) begin
        chk1("sb_unexpected_event", 1'b1, 1'b0);
      end else begin
        sb_ev = sbq.pop_front();
        chk1("sb_kind", err, sb_ev.is_err);
        if (sb_ev.is_err)
          chk("sb_code", 192'(err_code), 192'(sb_ev.code));
        else
          chk("sb_ops", {k_o ^ px_o ^ py_o},
              {sb_ev.k ^ sb_ev.px ^ sb_ev.py});
        if (!sb_ev.is_err) begin
          chk("sb_k", k_o, sb_ev.k);
          chk("sb_px", px_o, sb_ev.px);
          chk("sb_py", py_o, sb_ev.py);
        end
      end
    end
  end

  function automatic logic [31:0] word_of(
      input logic [191:0] kk, input logic [191:0] xx,
      input logic [191:0] yy, input int i);
    logic [575:0] all;
    all = {kk, xx, yy};
    return all[575-32*i -: 32];
  endfunction

  task automatic load_set(input rec_t v, input bit toggle);
    for (int i = 0; i < NW; i++) begin
      if (toggle) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = word_of(v.k, v.px, v.py, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Load a set, check CHECK/FIRE timing, then answer after lat cycles.
  task automatic run_vec(input rec_t v, input int lat,
                         input bit toggle);
    bit stable;
    sbq.push_back(v);
    load_set(v, toggle);
    @(negedge clk);
    chk1("check_in_ready", in_ready, 1'b0);
    chk1("check_no_start", start, 1'b0);
    chk1("check_no_err", err, 1'b0);
    @(negedge clk);
    if (v.is_err) begin
      chk1("err_pulse", err, 1'b1);
      chk("err_code", 192'(err_code), 192'(v.code));
      chk1("err_in_ready", in_ready, 1'b1);
      chk1("err_no_start", start, 1'b0);
      @(posedge clk); #1;
      chk1("err_one_cycle", err, 1'b0);
      chk1("err_code_hold", err_code == v.code, 1'b1);
    end else begin
      chk1("fire_start", start, 1'b1);
      chk1("fire_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
      chk1("wait_busy", busy, 1'b1);
      chk1("start_one_cycle", start, 1'b0);
      stable = 1'b1;
      for (int c = 0; c < lat; c++) begin
        if (k_o !== v.k || px_o !== v.px || py_o !== v.py || start)
          stable = 1'b0;
        @(posedge clk); #1;
      end
      mul_valid = 1'b1;
      @(posedge clk); #1;
      mul_valid = 1'b0;
      chk1("ops_stable", stable, 1'b1);
      chk1("done_pulse", done, 1'b1);
      chk1("done_busy_low", busy, 1'b0);
      chk1("done_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      chk1("done_one_cycle", done, 1'b0);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk1({nm, "_in_ready"}, in_ready, 1'b1);
    chk("outs_low", {start, busy, done, err, err_code}, '0);
    chk({nm, "_k"}, k_o, '0);
    chk({nm, "_px"}, px_o, '0);
    chk({nm, "_py"}, py_o, '0);
    chk({nm, "_t_idle"}, {t_busy, t_err, t_code, t_in_ready}, 192'd1);
  endtask

  initial begin
    rec_t junk;
    rec_t v;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    mul_valid = 1'b0; in_data = '0;

    vecs[0] = '{k: 192'd1, px: GX, py: GY, is_err: 1'b0, code: 2'd0};
    vecs[1] = '{k: '0, px: GX, py: GY, is_err: 1'b1, code: 2'd1};
    vecs[2] = '{k: 192'd5, px: PRIME, py: GY, is_err: 1'b1, code: 2'd2};
    vecs[3] = '{k: 192'd5, px: GX, py: PRIME - 192'd1,
                is_err: 1'b0, code: 2'd0};
    vecs[4] = '{k: '1, px: PRIME - 192'd1, py: '0,
                is_err: 1'b0, code: 2'd0};
    vecs[5] = '{k: '0, px: PRIME, py: GY, is_err: 1'b1, code: 2'd1};
    vecs[6] = '{k: 192'd7, px: GX, py: PRIME + 192'd5,
                is_err: 1'b1, code: 2'd2};

    #12;
    chk_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_vec(vecs[i], (i == 0) ? 99 : 5, 1'b0);

    // Reset while the tenth word is on the bus.
    v = vecs[3];
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = word_of(v.k, v.px, v.py, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = word_of(v.k, v.px, v.py, 9);
    #2 rst = 1'b1;
    #1 chk_reset("rst_load");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0], 99, 1'b0);

    // Toggled valid with a flush after word 7; flush-cycle word dropped.
    junk = '{k: {6{32'hA5A5_0001}}, px: {6{32'h1234_5678}},
             py: {6{32'h0F0F_0F0F}}, is_err: 1'b0, code: 2'd0};
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = word_of(junk.k, junk.px, junk.py, i);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    flush    = 1'b1;
    in_data  = word_of(junk.k, junk.px, junk.py, 7);
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    v = '{k: 192'd3, px: GY, py: GX, is_err: 1'b0, code: 2'd0};
    run_vec(v, 5, 1'b1);

    // Timeout on the TIMEOUT=16 instance.
    v = '{k: 192'd9, px: GX, py: GY, is_err: 1'b0, code: 2'd0};
    sbq.push_back(v);
    load_set(v, 1'b0);
    repeat (17) begin @(posedge clk); #1; end
    chk1("to_not_yet", t_err, 1'b0);
    chk1("to_busy", t_busy, 1'b1);
    @(posedge clk); #1;
    chk1("to_err", t_err, 1'b1);
    chk("to_code", 192'(t_code), 192'd3);
    chk1("to_in_ready", t_in_ready, 1'b1);
    chk1("to_busy_low", t_busy, 1'b0);
    mul_valid = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    chk1("to_main_done", done, 1'b1);
    chk1("to_late_valid_ignored", t_done, 1'b0);

    // mul_valid on the timeout cycle wins.
    sbq.push_back(v);
    load_set(v, 1'b0);
    repeat (17) begin @(posedge clk); #1; end
    mul_valid = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    chk1("tie_done", t_done, 1'b1);
    chk1("tie_no_err", t_err, 1'b0);
    chk("tie_code", 192'(t_code), 192'd0);
    chk1("tie_main_done", done, 1'b1);

    // Reset while waiting on the multiplier.
    sbq.push_back(vecs[4]);
    load_set(vecs[4], 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    chk1("rw_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset("rst_wait");
    @(posedge clk); #1;
    rst = 1'b0;
    run_vec(vecs[0], 99, 1'b0);

    chk("sb_drained", 192'(sbq.size()), 192'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ecdh_operand_loader.md
# ecdh_operand_loader

Front-end stage that feeds the ECDH scalar-point multiplier. It accepts the scalar k and the base point (Px, Py) as a stream of narrow words over a valid/ready handshake and assembles them into full-width operands. It range-checks the operands, issues a one-cycle start pulse to the multiplier and holds the operands stable while the multiplier runs. It then waits for the multiplier's result-valid pulse, or a watchdog timeout, before accepting the next operand set.

## Interface
Parameters:
- BW, 192: field element width; matches `BW_GF.
- W, 32: input word width; BW must be a multiple of W.
- PRIME, P-192 prime 0xFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFFFFFFFFFFFF: field modulus; matches `PRIME.
- TIMEOUT, 2^20: maximum number of WAIT cycles before a timeout error.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  loader can accept a word.
- in_data  in  W  operand word.
- flush  in  1  discard a partially loaded operand set.
- k  out  BW  scalar to the multiplier.
- Px  out  BW  base point x to the multiplier.
- Py  out  BW  base point y to the multiplier.
- start  out  1  one-cycle start pulse to the multiplier.
- mul_valid  in  1  multiplier result-valid pulse.
- busy  out  1  multiplier operation in flight.
- done  out  1  one-cycle pulse: the multiplier completed.
- err  out  1  one-cycle pulse: operand set rejected, or timeout.
- err_code  out  2  error cause: 0 none, 1 k==0, 2 coordinate ≥ PRIME, 3 timeout.

## Operation
- Storage: a 3·BW shift register holding {k, Px, Py}.
  - Each accepted word shifts in at the LSB end.
  - Word order: k first, then Px, then Py; most-significant word first within each operand.
  - Total of 3·BW/W words per set (18 at the defaults).
- k, Px and Py are driven directly from the shift register. They change only in LOAD, so they stay stable from FIRE through the end of WAIT. The multiplier samples k every bit-scan cycle and Px/Py during point addition, so this stability is required.
- Word counter: ceil(log2(3·BW/W)) bits; cleared on reset, on flush in LOAD, and on entry to CHECK.
- States:
  - LOAD:
    - in_ready=1; a word is accepted when in_valid & in_ready, and the counter increments.
    - Accepting the last word (counter = 3·BW/W−1) → CHECK.
    - flush=1 clears the counter and takes priority over a simultaneous word accept (that word is dropped).
  - CHECK (1 cycle), in_ready=0:
    - If k==0: err_code=1, err pulse → LOAD.
    - Else if Px ≥ PRIME or Py ≥ PRIME: err_code=2, err pulse → LOAD.
    - Else: err_code=0 → FIRE.
  - FIRE (1 cycle): start=1, watchdog cleared → WAIT.
  - WAIT: busy=1, in_ready=0; the watchdog increments each cycle.
    - mul_valid=1: done pulse → LOAD.
    - Watchdog reaches TIMEOUT−1 with no mul_valid: err_code=3, err pulse → LOAD.
    - If mul_valid and timeout occur in the same cycle, mul_valid wins: done, no error.
- mul_valid is ignored outside WAIT.
- flush is ignored outside LOAD; an in-flight multiplication cannot be aborted by the loader.
- err_code holds its value until the next CHECK or timeout overwrites it.
- The shift register is not cleared after an error; the next set overwrites it completely.

## Timing
- Reset values:
  - state=LOAD, so in_ready=1.
  - start, busy, done, err = 0.
  - err_code=0.
  - k, Px, Py = 0.
  - Word counter and watchdog = 0.
- Last word accepted at cycle N:
  - CHECK at N+1.
  - start high at N+2 only.
  - busy high from N+3.
- mul_valid high at cycle c (in WAIT):
  - done high at c+1.
  - busy low and in_ready high at c+1.
- Error detected in CHECK at cycle m: err high and err_code valid at m+1, with in_ready=1 in the same cycle.
- start, done and err are registered or state-decoded outputs and are glitch-free.
- start is never asserted twice without an intervening done or timeout.
- Throughput: one operand set per (3·BW/W + 2 + multiplier latency + 1) cycles when in_valid is held high.
- Reset asserted mid-operation forces LOAD immediately (asynchronously). The system must reset the multiplier in the same event.

## Test plan
- Valid load, back-to-back words: k=1, Px=0x188DA80EB03090F67CBF20EB43A18800F4FF0AFD82FF1012, Py=0x07192B95FFC8DA78631011ED6B24CDD573F977A11E794811.
  - start pulses exactly 2 cycles after the 18th word.
  - k/Px/Py match the inputs and stay stable.
  - mul_valid 100 cycles later → done 1 cycle later, busy deasserts.
- k=0 with a valid point: no start; err=1 with err_code=1 two cycles after the last word; in_ready=1 in that cycle.
- Px=PRIME (k=5): err_code=2. Py=PRIME−1: accepted, start issued.
- in_valid toggled every other cycle plus a flush after word 7:
  - flush drops the partial set.
  - The next 18 words form the operands.
  - A word presented in the same cycle as flush is not counted.
- Timeout, with TIMEOUT=16 and no mul_valid: err_code=3 after 16 WAIT cycles. A repeat run with mul_valid on the timeout cycle gives done=1, err=0.
- Reset asserted during WAIT and during word 10 of LOAD:
  - All outputs return to their reset values immediately.
  - A following full load behaves as in the first scenario.
